// File: rtl/frost32_decode_ctrl.sv
// frost32_decode_ctrl
//   Decode-stage sequencer for the Frost32 pipeline. A one-entry decode
//   register accepts fetched words and feeds the core's only instruction
//   decoder. A pending-write scoreboard stalls register-read hazards, and
//   decoded fields are issued to execute through a registered valid/ready slot.
//
//   Optional feature: define DECODE_STALL_CNT_EN to build a saturating 32-bit
//   hazard-stall cycle counter. Without the macro, o_stall_cnt is tied to zero.
//
//   Instruction layout (INSTR_W = 32):
//     [31:28] group  [27:24] opcode  [23:20] ra  [19:16] rb  [15:12] rc
//     [15:0]  immediate, which is decoded for group 1 only
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_if_valid          fetch presents i_if_instr
//   i_if_instr          fetched instruction word
//   o_if_ready          decode register can accept a word this cycle (comb)
//   i_flush             discard the held word and the output slot
//   i_wb_valid          writeback retires a register write
//   i_wb_index          register being written back
//   o_ex_valid          output slot holds a decoded instruction
//   i_ex_ready          execute consumes the slot this cycle
//   o_ex_group          decoded group
//   o_ex_opcode         decoded opcode
//   o_ex_ra/rb/rc       decoded register indices
//   o_ex_imm            decoded immediate
//   o_stall_cnt         hazard-stall cycle count

module frost32_decode_ctrl #(
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned GROUP_W  = 4,
    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_if_valid,
    input  logic [INSTR_W-1:0]   i_if_instr,
    output logic                 o_if_ready,
    input  logic                 i_flush,
    input  logic                 i_wb_valid,
    input  logic [REG_IDX_W-1:0] i_wb_index,
    output logic                 o_ex_valid,
    input  logic                 i_ex_ready,
    output logic [GROUP_W-1:0]   o_ex_group,
    output logic [OPCODE_W-1:0]  o_ex_opcode,
    output logic [REG_IDX_W-1:0] o_ex_ra,
    output logic [REG_IDX_W-1:0] o_ex_rb,
    output logic [REG_IDX_W-1:0] o_ex_rc,
    output logic [IMM_W-1:0]     o_ex_imm,
    output logic [31:0]          o_stall_cnt
);

    // Field positions, packed from the MSB down.
    localparam int unsigned GRP_LSB = INSTR_W - GROUP_W;
    localparam int unsigned OPC_LSB = GRP_LSB - OPCODE_W;
    localparam int unsigned RA_LSB  = OPC_LSB - REG_IDX_W;
    localparam int unsigned RB_LSB  = RA_LSB - REG_IDX_W;
    localparam int unsigned RC_LSB  = RB_LSB - REG_IDX_W;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    state_t                r_state;
    logic [INSTR_W-1:0]    r_instr;
    logic [NUM_REGS-1:0]   r_pending;
    logic                  r_ex_valid;
    logic [GROUP_W-1:0]    r_ex_group;
    logic [OPCODE_W-1:0]   r_ex_opcode;
    logic [REG_IDX_W-1:0]  r_ex_ra;
    logic [REG_IDX_W-1:0]  r_ex_rb;
    logic [REG_IDX_W-1:0]  r_ex_rc;
    logic [IMM_W-1:0]      r_ex_imm;

    logic [GROUP_W-1:0]    w_group;
    logic [OPCODE_W-1:0]   w_opcode;
    logic [REG_IDX_W-1:0]  w_ra;
    logic [REG_IDX_W-1:0]  w_rb;
    logic [REG_IDX_W-1:0]  w_rc;
    logic [IMM_W-1:0]      w_imm;
    logic                  w_use_rc;
    logic                  w_hazard;
    logic                  w_slot_free;
    logic                  w_issue;
    logic                  w_accept;
    logic [NUM_REGS-1:0]   w_set_mask;
    logic [NUM_REGS-1:0]   w_clr_mask;

    // Instruction decoder. Groups 0, 2, 3 and any invalid group share the
    // default path: no immediate, and both rb and rc are sources.
    always_comb begin
        w_group  = r_instr[GRP_LSB +: GROUP_W];
        w_opcode = r_instr[OPC_LSB +: OPCODE_W];
        w_ra     = r_instr[RA_LSB +: REG_IDX_W];
        w_rb     = r_instr[RB_LSB +: REG_IDX_W];
        w_rc     = r_instr[RC_LSB +: REG_IDX_W];
        w_imm    = '0;
        w_use_rc = 1'b1;
        case (w_group)
            GROUP_W'(1): begin
                w_imm    = r_instr[IMM_W-1:0];
                w_use_rc = 1'b0;
            end
            default: ;
        endcase
    end

    // Hazard against registered pending bits only; register 0 never blocks.
    assign w_hazard = (r_state == ST_HELD) &&
                      (((w_rb != '0) && r_pending[w_rb]) ||
                       (w_use_rc && (w_rc != '0) && r_pending[w_rc]));

    assign w_slot_free = !r_ex_valid || i_ex_ready;
    assign w_issue     = (r_state == ST_HELD) && !w_hazard && w_slot_free && !i_flush;
    assign o_if_ready  = !i_flush && ((r_state == ST_EMPTY) || w_issue);
    assign w_accept    = i_if_valid && o_if_ready;

    // Scoreboard updates: clear on writeback, set on issue; set applied last so it wins.
    assign w_set_mask = (w_issue && (w_ra != '0)) ? (NUM_REGS'(1) << w_ra) : '0;
    assign w_clr_mask = i_wb_valid ? (NUM_REGS'(1) << i_wb_index) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_EMPTY;
            r_instr     <= '0;
            r_pending   <= '0;
            r_ex_valid  <= 1'b0;
            r_ex_group  <= '0;
            r_ex_opcode <= '0;
            r_ex_ra     <= '0;
            r_ex_rb     <= '0;
            r_ex_rc     <= '0;
            r_ex_imm    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;

            if (i_flush) begin
                // Flush drops both stages; the scoreboard is left alone.
                r_state    <= ST_EMPTY;
                r_ex_valid <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_instr <= i_if_instr;
                    r_state <= ST_HELD;
                end else if (w_issue) begin
                    r_state <= ST_EMPTY;
                end

                if (w_issue) begin
                    r_ex_valid  <= 1'b1;
                    r_ex_group  <= w_group;
                    r_ex_opcode <= w_opcode;
                    r_ex_ra     <= w_ra;
                    r_ex_rb     <= w_rb;
                    r_ex_rc     <= w_rc;
                    r_ex_imm    <= w_imm;
                end else if (i_ex_ready) begin
                    r_ex_valid <= 1'b0;
                end
            end
        end
    end

`ifdef DECODE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles a held word is blocked by a hazard.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !i_flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = 32'd0;
`endif

    assign o_ex_valid  = r_ex_valid;
    assign o_ex_group  = r_ex_group;
    assign o_ex_opcode = r_ex_opcode;
    assign o_ex_ra     = r_ex_ra;
    assign o_ex_rb     = r_ex_rb;
    assign o_ex_rc     = r_ex_rc;
    assign o_ex_imm    = r_ex_imm;

endmodule

// File: tb/tb_frost32_decode_ctrl.sv
// Testbench for frost32_decode_ctrl: scoreboard of accepted words checked
// against the issue stream, plus cycle-exact handshake and hazard checks.

module tb_frost32_decode_ctrl;

    logic        clk;
    logic        i_rst;
    logic        i_if_valid;
    logic [31:0] i_if_instr;
    logic        o_if_ready;
    logic        i_flush;
    logic        i_wb_valid;
    logic [3:0]  i_wb_index;
    logic        o_ex_valid;
    logic        i_ex_ready;
    logic [3:0]  o_ex_group;
    logic [3:0]  o_ex_opcode;
    logic [3:0]  o_ex_ra;
    logic [3:0]  o_ex_rb;
    logic [3:0]  o_ex_rc;
    logic [15:0] o_ex_imm;
    logic [31:0] o_stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    frost32_decode_ctrl dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_if_valid  (i_if_valid),
        .i_if_instr  (i_if_instr),
        .o_if_ready  (o_if_ready),
        .i_flush     (i_flush),
        .i_wb_valid  (i_wb_valid),
        .i_wb_index  (i_wb_index),
        .o_ex_valid  (o_ex_valid),
        .i_ex_ready  (i_ex_ready),
        .o_ex_group  (o_ex_group),
        .o_ex_opcode (o_ex_opcode),
        .o_ex_ra     (o_ex_ra),
        .o_ex_rb     (o_ex_rb),
        .o_ex_rc     (o_ex_rc),
        .o_ex_imm    (o_ex_imm),
        .o_stall_cnt (o_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word layout: group, opcode, ra, rb, then 16 low bits (rc in the top nibble).
    function automatic logic [31:0] mk(input logic [3:0] g, input logic [3:0] op,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [15:0] lo);
        return {g, op, ra, rb, lo};
    endfunction

    // Non-immediate form; low 12 bits carry junk that must not reach ex_imm.
    function automatic logic [31:0] mk3(input logic [3:0] g, input logic [3:0] op,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [3:0] rc);
        return mk(g, op, ra, rb, {rc, 12'hA5C});
    endfunction

    // Expected decoded fields {group, opcode, ra, rb, rc, imm}.
    function automatic logic [63:0] exp_of(input logic [31:0] w);
        logic [15:0] imm;
        imm = (w[31:28] == 4'd1) ? w[15:0] : 16'h0000;
        return {28'h0, w[31:12], imm};
    endfunction

    function automatic logic [63:0] obs_fields();
        return {28'h0, o_ex_group, o_ex_opcode, o_ex_ra, o_ex_rb, o_ex_rc, o_ex_imm};
    endfunction

    function automatic logic [63:0] stall_exp(input int n);
`ifdef DECODE_STALL_CNT_EN
        return 64'(n);
`else
        return 64'(n) & 64'h0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch word; it enters the scoreboard only if the DUT will accept it.
    task automatic offer(input logic [31:0] w);
        i_if_valid = 1'b1;
        i_if_instr = w;
        #1;
        if (o_if_ready) sb_q.push_back(w);
    endtask

    task automatic idle();
        i_if_valid = 1'b0;
        #1;
    endtask

    // Every slot transfer is compared in order against the accepted words.
    always @(negedge clk) begin
        if (!i_rst && o_ex_valid && i_ex_ready) begin
            check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) check_eq("sb_fields", obs_fields(), exp_of(sb_q.pop_front()));
        end
    end

    initial begin
        logic [31:0] s2 [4];
        logic [31:0] w_c;

        i_rst = 1'b1; i_if_valid = 1'b0; i_if_instr = '0; i_flush = 1'b0;
        i_wb_valid = 1'b0; i_wb_index = '0; i_ex_ready = 1'b0;

        // Reset
        tick(); tick();
        i_rst = 1'b0;
        #1;
        check_eq("rst_if_ready", 64'(o_if_ready), 64'd1);
        check_eq("rst_ex_valid", 64'(o_ex_valid), 64'd0);
        check_eq("rst_fields", obs_fields(), 64'd0);
        check_eq("rst_stall", 64'(o_stall_cnt), 64'd0);

        // Four independent group-0 words streamed with execute always ready
        s2[0] = mk3(4'd0, 4'd1, 4'd8,  4'd12, 4'd13);
        s2[1] = mk3(4'd0, 4'd2, 4'd9,  4'd0,  4'd14);
        s2[2] = mk3(4'd0, 4'd3, 4'd10, 4'd15, 4'd0);
        s2[3] = mk3(4'd0, 4'd4, 4'd11, 4'd12, 4'd15);
        i_ex_ready = 1'b1;
        offer(s2[0]);
        check_eq("s2_rdy", 64'(o_if_ready), 64'd1);
        tick();
        for (int t = 1; t <= 6; t++) begin
            check_eq("s2_valid", 64'(o_ex_valid), 64'((t >= 2) && (t <= 5)));
            if (t <= 3) begin
                offer(s2[t]);
                check_eq("s2_rdy", 64'(o_if_ready), 64'd1);
            end else begin
                idle();
            end
            tick();
        end

        // RAW hazard on r3, released by writeback in cycle 6
        offer(mk3(4'd0, 4'd6, 4'd3, 4'd0, 4'd0));
        tick();
        offer(mk3(4'd2, 4'd7, 4'd6, 4'd3, 4'd0));
        check_eq("s3_refill_rdy", 64'(o_if_ready), 64'd1);
        tick();
        for (int c = 2; c <= 6; c++) begin
            i_wb_valid = (c == 6);
            i_wb_index = 4'd3;
            idle();
            check_eq("s3_stall_rdy", 64'(o_if_ready), 64'd0);
            tick();
        end
        i_wb_valid = 1'b0;
        idle();
        check_eq("s3_issue_rdy", 64'(o_if_ready), 64'd1);
        check_eq("s3_valid_pre", 64'(o_ex_valid), 64'd0);
        tick();
        check_eq("s3_valid", 64'(o_ex_valid), 64'd1);
        check_eq("s3_stall_cnt", 64'(o_stall_cnt), stall_exp(5));
        tick();

        // Execute back-pressure with the slot full and a word held
        i_ex_ready = 1'b0;
        w_c = mk3(4'd3, 4'd9, 4'd13, 4'd0, 4'd0);
        offer(w_c);
        tick();
        offer(mk(4'd1, 4'd5, 4'd14, 4'd1, 16'h1234));
        tick();
        for (int k = 0; k < 3; k++) begin
            idle();
            check_eq("s4_hold_valid", 64'(o_ex_valid), 64'd1);
            check_eq("s4_hold_fields", obs_fields(), exp_of(w_c));
            check_eq("s4_hold_rdy", 64'(o_if_ready), 64'd0);
            tick();
        end
        i_ex_ready = 1'b1;
        idle();
        tick();
        check_eq("s4_drain_valid", 64'(o_ex_valid), 64'd1);
        tick();

        // Flush with a word held and the slot full; r5 stays pending
        i_ex_ready = 1'b0;
        offer(mk3(4'd0, 4'd8, 4'd5, 4'd0, 4'd0));
        tick();
        offer(mk3(4'd2, 4'd1, 4'd1, 4'd0, 4'd0));
        tick();
        i_flush = 1'b1;
        offer(mk3(4'd0, 4'd2, 4'd2, 4'd0, 4'd0));
        check_eq("s5_flush_rdy", 64'(o_if_ready), 64'd0);
        tick();
        i_flush = 1'b0;
        idle();
        check_eq("s5_flush_valid", 64'(o_ex_valid), 64'd0);
        check_eq("s5_empty_rdy", 64'(o_if_ready), 64'd1);
        sb_q.delete();
        i_ex_ready = 1'b1;
        offer(mk3(4'd0, 4'd3, 4'd4, 4'd5, 4'd0));
        tick();
        idle();
        check_eq("s5_pend_rdy", 64'(o_if_ready), 64'd0);
        tick();
        i_wb_valid = 1'b1;
        i_wb_index = 4'd5;
        idle();
        check_eq("s5_pend_rdy2", 64'(o_if_ready), 64'd0);
        check_eq("s5_pend_valid", 64'(o_ex_valid), 64'd0);
        tick();
        i_wb_valid = 1'b0;
        idle();
        check_eq("s5_wb_rdy", 64'(o_if_ready), 64'd1);
        tick();
        check_eq("s5_valid", 64'(o_ex_valid), 64'd1);
        check_eq("s5_stall_cnt", 64'(o_stall_cnt), stall_exp(7));
        tick();

        // Set beats clear on r7; group 1 ignores its rc field
        offer(mk3(4'd0, 4'd4, 4'd7, 4'd0, 4'd0));
        tick();
        i_wb_valid = 1'b1;
        i_wb_index = 4'd7;
        offer(mk(4'd1, 4'd6, 4'd11, 4'd2, 16'h7ABC));
        check_eq("s6_rdy", 64'(o_if_ready), 64'd1);
        tick();
        i_wb_valid = 1'b0;
        offer(mk3(4'd0, 4'd10, 4'd0, 4'd7, 4'd0));
        check_eq("s6_grp1_nostall", 64'(o_if_ready), 64'd1);
        tick();
        idle();
        check_eq("s6_k_valid", 64'(o_ex_valid), 64'd1);
        check_eq("s6_set_wins", 64'(o_if_ready), 64'd0);
        tick();
        i_wb_valid = 1'b1;
        i_wb_index = 4'd7;
        idle();
        tick();
        i_wb_valid = 1'b0;
        idle();
        check_eq("s6_l_rdy", 64'(o_if_ready), 64'd1);
        tick();
        check_eq("s6_l_valid", 64'(o_ex_valid), 64'd1);
        check_eq("s6_stall_cnt", 64'(o_stall_cnt), stall_exp(9));
        // Invalid group passes through with a zero immediate
        offer(mk(4'hC, 4'd5, 4'd0, 4'd0, 16'hFFFF));
        tick();
        idle();
        tick();
        check_eq("inv_valid", 64'(o_ex_valid), 64'd1);
        tick();

        // Reset mid-operation, then confirm the scoreboard was cleared
        i_ex_ready = 1'b0;
        offer(mk3(4'd0, 4'd1, 4'd3, 4'd0, 4'd0));
        tick();
        offer(mk3(4'd0, 4'd2, 4'd6, 4'd0, 4'd0));
        tick();
        i_rst = 1'b1;
        i_if_valid = 1'b1;
        tick();
        i_rst = 1'b0;
        i_if_valid = 1'b0;
        #1;
        sb_q.delete();
        check_eq("rst2_valid", 64'(o_ex_valid), 64'd0);
        check_eq("rst2_fields", obs_fields(), 64'd0);
        check_eq("rst2_stall", 64'(o_stall_cnt), 64'd0);
        check_eq("rst2_rdy", 64'(o_if_ready), 64'd1);
        i_ex_ready = 1'b1;
        offer(mk3(4'd0, 4'd11, 4'd2, 4'd3, 4'd6));
        tick();
        idle();
        check_eq("rst2_nohaz_rdy", 64'(o_if_ready), 64'd1);
        tick();
        check_eq("rst2_issue_valid", 64'(o_ex_valid), 64'd1);
        tick();
        idle();

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
